hash_msg_feeder: RTL and testbench

Upstream message-formatting stage for `hash_function`. Accepts a byte stream with a last-byte marker, packs it into 4-byte blocks, appends padding and an optional length block, and sequences the core one block at a time. Each block's digest is chained as the next block's IV (Merkle–Damgård). Presents the final digest to the consumer as a one-cycle valid pulse.

---
 rtl/hash_msg_feeder_if.sv | 24 ++
 rtl/hash_msg_feeder.sv | 185 ++++++++++++++++++
 tb/tb_hash_msg_feeder.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_msg_feeder_if.sv
// Byte-stream handshake into hash_msg_feeder: one message byte per transfer,
// with in_last qualifying the final byte of a message.
// Ports: in_valid/in_data/in_last driven by the source, in_ready by the sink.
// master = upstream byte source, slave = hash_msg_feeder.
interface hash_msg_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/hash_msg_feeder.sv
// Packs a byte stream into 4-byte blocks, pads, optionally appends a length block,
// and sequences hash_function one block at a time with Merkle-Damgard chaining.
// Latency: 4th byte -> core_start next cycle; core_done -> next block/digest one cycle later.
// Backpressure: in_ready low outside COLLECT; digest_valid is a pulse with no backpressure.
//
// Ports:
//   clk, rst_n     : single clock, asynchronous active-low reset
//   msg (slave)    : in_valid/in_ready/in_data/in_last byte stream
//   core_start     : one-cycle start to the core
//   core_m[0:3]    : block bytes, core_m[0] earliest
//   core_iv[0:3]   : chaining value (always equals the chain register)
//   core_d[0:3]    : core digest, core_done : core completion (level or pulse)
//   digest_valid   : one-cycle pulse, digest[0:3] held until the next pulse
// Build option: define HASH_LEN_BLOCK_EN to append a 32-bit big-endian byte-count block.
module hash_msg_feeder #(
  parameter logic [31:0] IV_INIT = 32'h34550F14
) (
  input  logic                clk,
  input  logic                rst_n,
  hash_msg_feeder_if.slave    msg,
  output logic                core_start,
  output logic [7:0]          core_m [4],
  output logic [7:0]          core_iv [4],
  input  logic [7:0]          core_d [4],
  input  logic                core_done,
  output logic                digest_valid,
  output logic [7:0]          digest [4]
);

  // IV byte 0 is the most significant byte of IV_INIT.
  localparam logic [7:0] IV_B [4] = '{IV_INIT[31:24], IV_INIT[23:16],
                                      IV_INIT[15:8],  IV_INIT[7:0]};

  typedef enum logic [2:0] {
    S_COLLECT,
    S_PAD,
    S_START,
    S_WAIT,
`ifdef HASH_LEN_BLOCK_EN
    S_LEN,
`endif
    S_OUT
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] byte_cnt;
  logic        last_seen;   // final byte landed in byte 3; padding needs its own block
  logic        pad_done;    // the padded block has been (or is being) hashed
`ifdef HASH_LEN_BLOCK_EN
  logic        len_done;    // the length block has been (or is being) hashed
`endif
  logic [7:0]  chain [4];

  assign core_iv = chain;

  // All outputs are registered: each transition sets the output values that
  // belong to the state being entered, so in_ready/core_start/digest_valid
  // line up exactly with COLLECT/START/OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_COLLECT;
      idx          <= 2'd0;
      byte_cnt     <= 32'd0;
      last_seen    <= 1'b0;
      pad_done     <= 1'b0;
`ifdef HASH_LEN_BLOCK_EN
      len_done     <= 1'b0;
`endif
      msg.in_ready <= 1'b1;
      core_start   <= 1'b0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        core_m[i] <= 8'h00;
        chain[i]  <= IV_B[i];
        digest[i] <= 8'h00;
      end
    end else begin
      core_start   <= 1'b0;
      digest_valid <= 1'b0;

      case (state)
        S_COLLECT: begin
          if (msg.in_valid && msg.in_ready) begin
            core_m[idx] <= msg.in_data;
            idx         <= idx + 2'd1;
            byte_cnt    <= byte_cnt + 32'd1;
            if (idx == 2'd3) begin
              // Block full: hash it now; if this was also the last byte,
              // the 0x80 marker goes into a fresh block afterwards.
              last_seen    <= msg.in_last;
              state        <= S_START;
              core_start   <= 1'b1;
              msg.in_ready <= 1'b0;
            end else if (msg.in_last) begin
              state        <= S_PAD;
              msg.in_ready <= 1'b0;
            end
          end
        end

        S_PAD: begin
          // idx already points one past the last message byte (0 for an
          // aligned message arriving from WAIT).
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == idx) begin
              core_m[i] <= 8'h80;
            end else if (2'(i) > idx) begin
              core_m[i] <= 8'h00;
            end
          end
          pad_done   <= 1'b1;
          state      <= S_START;
          core_start <= 1'b1;
        end

        S_START: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // core_m/chain are untouched until here, so the core sees stable
          // inputs for the whole hash.
          if (core_done) begin
            chain <= core_d;
            idx   <= 2'd0;
            if (pad_done) begin
`ifdef HASH_LEN_BLOCK_EN
              if (!len_done) begin
                state <= S_LEN;
              end else begin
                state        <= S_OUT;
                digest_valid <= 1'b1;
                digest       <= core_d;
              end
`else
              state        <= S_OUT;
              digest_valid <= 1'b1;
              digest       <= core_d;
`endif
            end else if (last_seen) begin
              state <= S_PAD;
            end else begin
              state        <= S_COLLECT;
              msg.in_ready <= 1'b1;
            end
          end
        end

`ifdef HASH_LEN_BLOCK_EN
        S_LEN: begin
          core_m[0]  <= byte_cnt[31:24];
          core_m[1]  <= byte_cnt[23:16];
          core_m[2]  <= byte_cnt[15:8];
          core_m[3]  <= byte_cnt[7:0];
          len_done   <= 1'b1;
          state      <= S_START;
          core_start <= 1'b1;
        end
`endif

        S_OUT: begin
          // Digest was captured on entry; re-arm for a fresh message.
          for (int i = 0; i < 4; i++) begin
            chain[i] <= IV_B[i];
          end
          byte_cnt     <= 32'd0;
          last_seen    <= 1'b0;
          pad_done     <= 1'b0;
`ifdef HASH_LEN_BLOCK_EN
          len_done     <= 1'b0;
`endif
          state        <= S_COLLECT;
          msg.in_ready <= 1'b1;
        end

        default: begin
          state        <= S_COLLECT;
          msg.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: core model returns d = m ^ iv three cycles after
// core_start; every block and digest is compared with a byte-queue reference
// that pads, appends the length (when HASH_LEN_BLOCK_EN) and XOR-chains.
module tb_hash_msg_feeder;
  localparam logic [31:0] IV = 32'h34550F14;

  logic clk;
  logic rst_n;
  logic core_start, core_done, digest_valid;
  logic [7:0] core_m [4];
  logic [7:0] core_iv [4];
  logic [7:0] core_d [4];
  logic [7:0] digest [4];

  hash_msg_feeder_if msg();

  hash_msg_feeder #(.IV_INIT(IV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg          (msg),
    .core_start   (core_start),
    .core_m       (core_m),
    .core_iv      (core_iv),
    .core_d       (core_d),
    .core_done    (core_done),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  wire [31:0] m_w   = {core_m[0], core_m[1], core_m[2], core_m[3]};
  wire [31:0] iv_w  = {core_iv[0], core_iv[1], core_iv[2], core_iv[3]};
  wire [31:0] dig_w = {digest[0], digest[1], digest[2], digest[3]};

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] obs_m[$], obs_iv[$], obs_dig[$];
  logic [31:0] exp_m[$], exp_iv[$], exp_dig[$];
  logic [7:0]  msg_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  // Core model and output monitor, sampled on the falling edge.
  initial begin
    int cnt;
    logic [31:0] res;
    cnt = 0;
    res = 32'd0;
    core_done = 1'b0;
    for (int i = 0; i < 4; i++) core_d[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        core_done = 1'b0;
      end else begin
        core_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_d[0] = res[31:24]; core_d[1] = res[23:16];
            core_d[2] = res[15:8];  core_d[3] = res[7:0];
            core_done = 1'b1;
          end
        end
        if (core_start) begin
          obs_m.push_back(m_w);
          obs_iv.push_back(iv_w);
          res = m_w ^ iv_w;
          cnt = 3;
        end
        if (digest_valid) obs_dig.push_back(dig_w);
      end
    end
  end

  // Reference: message bytes + 0x80 + zero fill to 4 bytes (+ length), XOR chain.
  function automatic void build_model();
    logic [7:0] s[$];
    logic [31:0] iv, blk, n;
    s = msg_q;
    n = 32'(msg_q.size());
    s.push_back(8'h80);
    while ((s.size() % 4) != 0) s.push_back(8'h00);
`ifdef HASH_LEN_BLOCK_EN
    s.push_back(n[31:24]); s.push_back(n[23:16]);
    s.push_back(n[15:8]);  s.push_back(n[7:0]);
`endif
    iv = IV;
    for (int b = 0; b < s.size() / 4; b++) begin
      blk = {s[4*b], s[4*b+1], s[4*b+2], s[4*b+3]};
      exp_m.push_back(blk);
      exp_iv.push_back(iv);
      iv = iv ^ blk;
    end
    exp_dig.push_back(iv);
  endfunction

  function automatic void clear_all();
    obs_m.delete(); obs_iv.delete(); obs_dig.delete();
    exp_m.delete(); exp_iv.delete(); exp_dig.delete();
  endfunction

  // Drive msg_q; returns on the falling edge right after the last handshake.
  task automatic send_msg(input int gap_max);
    int g;
    int w;
    for (int i = 0; i < msg_q.size(); i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) @(negedge clk);
      for (w = 0; w < 500 && msg.in_ready !== 1'b1; w++) @(negedge clk);
      if (msg.in_ready !== 1'b1) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: in_ready=%b required 1", msg.in_ready);
        return;
      end
      msg.in_valid = 1'b1;
      msg.in_data  = msg_q[i];
      msg.in_last  = (i == msg_q.size() - 1);
      @(negedge clk);
      msg.in_valid = 1'b0;
      msg.in_last  = 1'b0;
    end
  endtask

  task automatic wait_dig(input int n);
    for (int k = 0; k < 400 && obs_dig.size() < n; k++) begin
      @(negedge clk); #1;
    end
    repeat (8) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    msg.in_valid = 1'b0; msg.in_data = 8'h00; msg.in_last = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (msg.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", msg.in_ready); end
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start: got %b want 0", core_start); end
    n_vec++; if (m_w !== 32'h0) begin n_err++; $display("FAIL rst_core_m: got %h want 0", m_w); end
    n_vec++; if (iv_w !== IV) begin n_err++; $display("FAIL rst_core_iv: got %h want %h", iv_w, IV); end
    n_vec++; if (digest_valid !== 1'b0 || dig_w !== 32'h0) begin n_err++; $display("FAIL rst_digest: got v=%b d=%h want v=0 d=0", digest_valid, dig_w); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unaligned;
    clear_all();
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_model();
    send_msg(0);
    wait_dig(1);
    n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL unal_nblocks: got %0d want %0d", obs_m.size(), exp_m.size()); end
    for (int b = 0; b < exp_m.size(); b++) begin
      n_vec++;
      if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
        n_err++; $display("FAIL unal_block%0d: got m=%h iv=%h want m=%h iv=%h", b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
      end
    end
    n_vec++; if (obs_dig.size() != 1 || obs_dig[0] !== exp_dig[0]) begin n_err++; $display("FAIL unal_digest: got n=%0d d=%h want n=1 d=%h", obs_dig.size(), obs_dig[0], exp_dig[0]); end
    n_vec++; if (dig_w !== exp_dig[0]) begin n_err++; $display("FAIL unal_digest_hold: got %h want %h", dig_w, exp_dig[0]); end
  endtask

  task automatic test_aligned;
    int bad;
    int k;
    clear_all();
    msg_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_model();
    send_msg(1);
    n_vec++; if (core_start !== 1'b1) begin n_err++; $display("FAIL al_start_latency: got core_start=%b want 1", core_start); end
    bad = 0;
    for (k = 0; k < 200 && digest_valid !== 1'b1; k++) begin
      if (msg.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++; if (bad != 0 || digest_valid !== 1'b1 || msg.in_ready !== 1'b0) begin n_err++; $display("FAIL al_in_ready_low: got %0d ready cycles, dv=%b want 0, dv=1", bad, digest_valid); end
    @(negedge clk);
    n_vec++; if (msg.in_ready !== 1'b1) begin n_err++; $display("FAIL al_ready_after_out: got %b want 1", msg.in_ready); end
    wait_dig(1);
    n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL al_nblocks: got %0d want %0d", obs_m.size(), exp_m.size()); end
    for (int b = 0; b < exp_m.size(); b++) begin
      n_vec++;
      if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
        n_err++; $display("FAIL al_block%0d: got m=%h iv=%h want m=%h iv=%h", b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
      end
    end
    n_vec++; if (obs_dig.size() != 1 || obs_dig[0] !== exp_dig[0]) begin n_err++; $display("FAIL al_digest: got n=%0d d=%h want n=1 d=%h", obs_dig.size(), obs_dig[0], exp_dig[0]); end
  endtask

  task automatic test_single;
    clear_all();
    msg_q = '{8'hFF};
    build_model();
    send_msg(0);
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL single_pad_cycle: got core_start=%b want 0", core_start); end
    @(negedge clk);
    n_vec++; if (core_start !== 1'b1) begin n_err++; $display("FAIL single_start_after_pad: got core_start=%b want 1", core_start); end
    wait_dig(1);
    repeat (20) @(negedge clk);
    #1;
    n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL single_nblocks: got %0d want %0d", obs_m.size(), exp_m.size()); end
    for (int b = 0; b < exp_m.size(); b++) begin
      n_vec++;
      if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
        n_err++; $display("FAIL single_block%0d: got m=%h iv=%h want m=%h iv=%h", b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
      end
    end
    n_vec++; if (obs_dig.size() != 1 || obs_dig[0] !== exp_dig[0]) begin n_err++; $display("FAIL single_digest: got n=%0d d=%h want n=1 d=%h", obs_dig.size(), obs_dig[0], exp_dig[0]); end
  endtask

  task automatic test_back_to_back;
    int nb;
    clear_all();
    msg_q = '{8'h11};
    build_model();
    nb = exp_m.size();
    send_msg(0);
    msg_q = '{8'h22};
    build_model();
    send_msg(0);
    wait_dig(2);
    n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL b2b_nblocks: got %0d want %0d", obs_m.size(), exp_m.size()); end
    n_vec++; if (nb >= obs_iv.size() || obs_iv[nb] !== IV) begin n_err++; $display("FAIL b2b_second_iv: got %h want %h", obs_iv[nb], IV); end
    for (int b = 0; b < exp_m.size(); b++) begin
      n_vec++;
      if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
        n_err++; $display("FAIL b2b_block%0d: got m=%h iv=%h want m=%h iv=%h", b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (d >= obs_dig.size() || obs_dig[d] !== exp_dig[d]) begin
        n_err++; $display("FAIL b2b_digest%0d: got %h want %h", d, obs_dig[d], exp_dig[d]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    clear_all();
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_msg(0);
    for (k = 0; k < 200 && obs_m.size() < 2; k++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (msg.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", msg.in_ready); end
    n_vec++; if (core_start !== 1'b0 || m_w !== 32'h0) begin n_err++; $display("FAIL mid_rst_core: got start=%b m=%h want 0 0", core_start, m_w); end
    n_vec++; if (iv_w !== IV) begin n_err++; $display("FAIL mid_rst_iv: got %h want %h", iv_w, IV); end
    n_vec++; if (digest_valid !== 1'b0 || dig_w !== 32'h0) begin n_err++; $display("FAIL mid_rst_digest: got v=%b d=%h want 0 0", digest_valid, dig_w); end
    n_vec++; if (obs_dig.size() != 0) begin n_err++; $display("FAIL mid_rst_aborted: got %0d digests want 0", obs_dig.size()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_all();
    build_model();
    send_msg(0);
    wait_dig(1);
    n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL mid_nblocks: got %0d want %0d", obs_m.size(), exp_m.size()); end
    for (int b = 0; b < exp_m.size(); b++) begin
      n_vec++;
      if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
        n_err++; $display("FAIL mid_block%0d: got m=%h iv=%h want m=%h iv=%h", b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
      end
    end
    n_vec++; if (obs_dig.size() != 1 || obs_dig[0] !== exp_dig[0]) begin n_err++; $display("FAIL mid_digest: got n=%0d d=%h want n=1 d=%h", obs_dig.size(), obs_dig[0], exp_dig[0]); end
  endtask

  task automatic test_random;
    int len;
    for (int t = 0; t < 8; t++) begin
      clear_all();
      msg_q.delete();
      len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      build_model();
      send_msg(2);
      wait_dig(1);
      n_vec++; if (obs_m.size() != exp_m.size()) begin n_err++; $display("FAIL rnd%0d_nblocks: len=%0d got %0d want %0d", t, len, obs_m.size(), exp_m.size()); end
      for (int b = 0; b < exp_m.size(); b++) begin
        n_vec++;
        if (b >= obs_m.size() || obs_m[b] !== exp_m[b] || obs_iv[b] !== exp_iv[b]) begin
          n_err++; $display("FAIL rnd%0d_block%0d: got m=%h iv=%h want m=%h iv=%h", t, b, obs_m[b], obs_iv[b], exp_m[b], exp_iv[b]);
        end
      end
      n_vec++; if (obs_dig.size() != 1 || obs_dig[0] !== exp_dig[0]) begin n_err++; $display("FAIL rnd%0d_digest: got n=%0d d=%h want n=1 d=%h", t, obs_dig.size(), obs_dig[0], exp_dig[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    msg.in_valid = 1'b0;
    msg.in_data  = 8'h00;
    msg.in_last  = 1'b0;
    test_reset();
    test_unaligned();
    test_aligned();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
